// File: rtl/net2axis_arbiter_pkg.sv
// Shared types for the net2axis packet arbiter: FSM state encoding and a
// width helper used for the round-robin pointer.
package net2axis_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ARB   = 3'd2,
    ST_XFER  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Bits needed to index n items; never less than 1 so a 1-bit pointer exists.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/net2axis_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping, found by scanning a doubled request vector.
module net2axis_rr_pick
  import net2axis_arbiter_pkg::*;
#(
  parameter int C_NUM_SRC = 2,
  localparam int PTR_W = clog2(C_NUM_SRC)
) (
  input  logic [C_NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 hit,
  output logic [C_NUM_SRC-1:0] grant,
  output logic [PTR_W-1:0]     idx
);

  logic [2*C_NUM_SRC-1:0] dbl;

  always_comb begin
    dbl   = {req, req};
    hit   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int j = 0; j < C_NUM_SRC; j++) begin
      if (!hit && dbl[int'(ptr) + j]) begin
        hit = 1'b1;
        idx = PTR_W'((int'(ptr) + j) % C_NUM_SRC);
        grant[(int'(ptr) + j) % C_NUM_SRC] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/net2axis_arbiter.sv
// Packet-level round-robin scheduler sharing one AXI4-Stream master port
// between C_NUM_SRC generators; a grant is held from arbitration until TLAST.
module net2axis_arbiter
  import net2axis_arbiter_pkg::*;
#(
  parameter int C_NUM_SRC       = 2,
  parameter int C_TDATA_WIDTH   = 32,
  parameter int C_COUNTER_WIDTH = 32
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic                                   ENABLE,
  input  logic                                   START,
  output logic [C_NUM_SRC-1:0]                   SRC_ENABLE,
  output logic [C_NUM_SRC-1:0]                   SRC_START,
  input  logic [C_NUM_SRC-1:0]                   SRC_DONE,
  input  logic [C_NUM_SRC-1:0]                   S_AXIS_TVALID,
  input  logic [C_NUM_SRC*C_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_NUM_SRC*C_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic [C_NUM_SRC-1:0]                   S_AXIS_TLAST,
  output logic [C_NUM_SRC-1:0]                   S_AXIS_TREADY,
  output logic                                   M_AXIS_TVALID,
  output logic [C_TDATA_WIDTH-1:0]               M_AXIS_TDATA,
  output logic [C_TDATA_WIDTH/8-1:0]             M_AXIS_TKEEP,
  output logic                                   M_AXIS_TLAST,
  input  logic                                   M_AXIS_TREADY,
  output logic [C_NUM_SRC-1:0]                   GRANT,
  output logic [C_COUNTER_WIDTH-1:0]             WORD_COUNTER,
  output logic [C_COUNTER_WIDTH-1:0]             PKT_COUNTER,
  output logic                                   ALL_DONE,
  output logic                                   BUSY,
  output state_t                                 DBG_STATE
);

  localparam int PTR_W = clog2(C_NUM_SRC);
  localparam int KW    = C_TDATA_WIDTH / 8;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     g_idx;
  logic [C_NUM_SRC-1:0] done_seen;
  logic                 pick_hit;
  logic [C_NUM_SRC-1:0] pick_grant;
  logic [PTR_W-1:0]     pick_idx;
  logic                 xfer;
  logic                 beat;
  logic [PTR_W-1:0]     ptr_next;

  net2axis_rr_pick #(.C_NUM_SRC(C_NUM_SRC)) u_pick (
    .req   (S_AXIS_TVALID),
    .ptr   (ptr),
    .hit   (pick_hit),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Handshake: a beat moves when TVALID and TREADY are both high at a rising
  // edge; only the granted source sees TREADY, so others hold their beat.
  assign xfer = (state == ST_XFER);
  assign beat = xfer && M_AXIS_TVALID && M_AXIS_TREADY;

  always_comb begin
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = '0;
    if (xfer) begin
      M_AXIS_TVALID        = S_AXIS_TVALID[g_idx];
      M_AXIS_TDATA         = S_AXIS_TDATA[g_idx*C_TDATA_WIDTH +: C_TDATA_WIDTH];
      M_AXIS_TKEEP         = S_AXIS_TKEEP[g_idx*KW +: KW];
      M_AXIS_TLAST         = S_AXIS_TLAST[g_idx];
      S_AXIS_TREADY[g_idx] = M_AXIS_TREADY;
    end
  end

  assign ptr_next  = (g_idx == PTR_W'(C_NUM_SRC - 1)) ? '0 : g_idx + PTR_W'(1);
  assign BUSY      = (state != ST_IDLE) && (state != ST_DONE);
  assign DBG_STATE = state;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      g_idx        <= '0;
      GRANT        <= '0;
      done_seen    <= '0;
      WORD_COUNTER <= '0;
      PKT_COUNTER  <= '0;
      SRC_ENABLE   <= '0;
      SRC_START    <= '0;
      ALL_DONE     <= 1'b0;
    end else begin
      SRC_ENABLE <= {C_NUM_SRC{ENABLE}};
      SRC_START  <= '0;
      if (state != ST_IDLE && state != ST_START)
        done_seen <= done_seen | SRC_DONE;
      if (beat)
        WORD_COUNTER <= WORD_COUNTER + C_COUNTER_WIDTH'(1);
      case (state)
        ST_IDLE: begin
          if (ENABLE && START) begin
            state     <= ST_START;
            SRC_START <= '1;
          end
        end
        ST_START: state <= ST_ARB;
        ST_ARB: begin
          // Clearing done_seen is written after the sticky set so it wins.
          if (!ENABLE) begin
            state     <= ST_IDLE;
            done_seen <= '0;
          end else if (pick_hit) begin
            GRANT <= pick_grant;
            g_idx <= pick_idx;
            state <= ST_XFER;
          end else if (&done_seen) begin
            state    <= ST_DONE;
            ALL_DONE <= 1'b1;
          end
        end
        ST_XFER: begin
          if (beat && M_AXIS_TLAST) begin
            PKT_COUNTER <= PKT_COUNTER + C_COUNTER_WIDTH'(1);
            ptr         <= ptr_next;
            GRANT       <= '0;
            state       <= ST_ARB;
          end
        end
        ST_DONE: begin
          if (!ENABLE) begin
            state     <= ST_IDLE;
            ALL_DONE  <= 1'b0;
            done_seen <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
